// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the memory loader: FSM encodings, load modes and strobe levels.
package mem_loader_pkg;

  localparam int unsigned ST_W = 3;
  typedef logic [ST_W-1:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_CLEAR = 3'd1;
  localparam state_t ST_LOAD  = 3'd2;
  localparam state_t ST_VRD   = 3'd3;
  localparam state_t ST_VCMP  = 3'd4;
  localparam state_t ST_DONE  = 3'd5;
  localparam state_t ST_ERR   = 3'd6;

  typedef enum logic [1:0] {
    MODE_CLR_LOAD = 2'b00,
    MODE_LOAD     = 2'b01,
    MODE_CLR      = 2'b10,
    MODE_VERIFY   = 2'b11
  } mode_e;

  // Active-low memory strobes: this is the idle level.
  localparam logic STROBE_OFF = 1'b1;

  function automatic logic is_busy(input state_t st);
    return (st == ST_CLEAR) || (st == ST_LOAD) || (st == ST_VRD) || (st == ST_VCMP);
  endfunction

endpackage

// File: rtl/mem_loader_if.sv
// Word-stream handshake plus the word-wide memory port of the loader.
interface mem_loader_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
) ();

  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_as_L;
  logic              mem_we_L;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  s_valid, s_data, mem_rdata,
    output s_ready, mem_addr, mem_wdata, mem_as_L, mem_we_L
  );

  modport slave (
    output s_valid, s_data, mem_rdata,
    input  s_ready, mem_addr, mem_wdata, mem_as_L, mem_we_L
  );

endinterface

// File: rtl/mem_loader_addr_gen.sv
// Remaining-word counter and byte-address generator; load has priority over advance.
module mem_loader_addr_gen #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned CNT_W  = 11,
  parameter int unsigned STEP   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [CNT_W-1:0]  load_cnt,
  input  logic              adv,
  output logic [ADDR_W-1:0] addr,
  output logic              last_c
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;

  always_comb begin
    addr_d = addr_q;
    rem_d  = rem_q;
    if (load) begin
      addr_d = load_base;
      rem_d  = load_cnt;
    end else if (adv) begin
      addr_d = addr_q + ADDR_W'(STEP);
      rem_d  = rem_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      rem_q  <= '0;
    end else begin
      addr_q <= addr_d;
      rem_q  <= rem_d;
    end
  end

  assign addr   = addr_q;
  assign last_c = (rem_q == CNT_W'(1));

endmodule

// File: rtl/mem_loader.sv
// Boot-image loader: clears memory, streams words into it, or verifies it, then releases the core.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int unsigned       ADDR_W        = 12,
  parameter int unsigned       DATA_W        = 32,
  parameter int unsigned       DEPTH         = 1024,
  parameter logic [DATA_W-1:0] CLEAR_VAL     = '0,
  parameter bit                HOLD_AT_RESET = 1'b1
) (
  input  logic                     CLOCK_50,
  input  logic                     RESET_L,
  input  logic                     start,
  input  logic [1:0]               mode,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [$clog2(DEPTH):0]   word_count,
  mem_loader_if.master             bus,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic                     core_hold_L,
  output logic [DATA_W-1:0]        checksum
);

  localparam int unsigned STEP  = DATA_W / 8;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned RW    = ADDR_W + CNT_W + 8;

  state_t            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] checksum_q, checksum_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              vfirst_q, vfirst_d;
  logic              error_q, error_d;
  logic              core_hold_q, core_hold_d;
  logic              busy_q, done_q;

  logic              gen_load, gen_adv, gen_last_c;
  logic [ADDR_W-1:0] gen_base, gen_addr;
  logic [CNT_W-1:0]  gen_cnt;

  logic              s_ready_c, hs_c, range_bad_c;
  logic              mem_as_c, mem_we_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] mem_wdata_c, cmp_data_c;

  mem_loader_addr_gen #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .STEP(STEP)) u_addr_gen (
    .clk       (CLOCK_50),
    .rst_n     (RESET_L),
    .load      (gen_load),
    .load_base (gen_base),
    .load_cnt  (gen_cnt),
    .adv       (gen_adv),
    .addr      (gen_addr),
    .last_c    (gen_last_c)
  );

  assign s_ready_c   = (state_q == ST_LOAD) || (state_q == ST_VCMP);
  assign hs_c        = bus.s_valid && s_ready_c;
  assign range_bad_c = (RW'(base_addr) + RW'(word_count) * RW'(STEP)) > (RW'(DEPTH) * RW'(STEP));
  // Read data arrives the cycle after VRD; later VCMP cycles use the captured copy.
  assign cmp_data_c  = vfirst_q ? bus.mem_rdata : rdata_q;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    base_d      = base_q;
    cnt_d       = cnt_q;
    checksum_d  = checksum_q;
    error_d     = error_q;
    rdata_d     = rdata_q;
    vfirst_d    = 1'b0;
    gen_load    = 1'b0;
    gen_adv     = 1'b0;
    gen_base    = base_q;
    gen_cnt     = cnt_q;
    mem_as_c    = STROBE_OFF;
    mem_we_c    = STROBE_OFF;
    mem_addr_c  = '0;
    mem_wdata_c = '0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (state_q == ST_DONE) state_d = ST_IDLE;
        if (start) begin
          mode_d     = mode_e'(mode);
          base_d     = base_addr;
          cnt_d      = word_count;
          checksum_d = '0;
          error_d    = 1'b0;
          gen_load   = 1'b1;
          gen_base   = base_addr;
          gen_cnt    = word_count;
          if (range_bad_c) begin
            state_d = ST_ERR;
          end else begin
            case (mode_e'(mode))
              MODE_CLR_LOAD, MODE_CLR: begin
                state_d  = ST_CLEAR;
                gen_base = '0;
                gen_cnt  = CNT_W'(DEPTH);
              end
              MODE_LOAD:   state_d = (word_count == '0) ? ST_DONE : ST_LOAD;
              default:     state_d = (word_count == '0) ? ST_DONE : ST_VRD;
            endcase
          end
        end
      end
      ST_CLEAR: begin
        mem_as_c    = 1'b0;
        mem_we_c    = 1'b0;
        mem_addr_c  = gen_addr;
        mem_wdata_c = CLEAR_VAL;
        gen_adv     = 1'b1;
        if (gen_last_c) begin
          if (mode_q == MODE_CLR) begin
            state_d = ST_DONE;
          end else begin
            gen_load = 1'b1;
            state_d  = (cnt_q == '0) ? ST_DONE : ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (hs_c) begin
          mem_as_c    = 1'b0;
          mem_we_c    = 1'b0;
          mem_addr_c  = gen_addr;
          mem_wdata_c = bus.s_data;
          gen_adv     = 1'b1;
          checksum_d  = checksum_q + bus.s_data;
          if (gen_last_c) state_d = ST_DONE;
        end
      end
      ST_VRD: begin
        mem_as_c   = 1'b0;
        mem_addr_c = gen_addr;
        vfirst_d   = 1'b1;
        state_d    = ST_VCMP;
      end
      ST_VCMP: begin
        if (vfirst_q) rdata_d = bus.mem_rdata;
        if (hs_c) begin
          if (bus.s_data != cmp_data_c) begin
            state_d = ST_ERR;
          end else begin
            gen_adv = 1'b1;
            state_d = gen_last_c ? ST_DONE : ST_VRD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_ERR) error_d = 1'b1;

    core_hold_d = core_hold_q;
    if (state_d == ST_DONE)                               core_hold_d = 1'b1;
    else if (is_busy(state_d) || (state_d == ST_ERR))     core_hold_d = 1'b0;
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_L) begin
    if (!RESET_L) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_CLR_LOAD;
      base_q      <= '0;
      cnt_q       <= '0;
      checksum_q  <= '0;
      rdata_q     <= '0;
      vfirst_q    <= 1'b0;
      error_q     <= 1'b0;
      core_hold_q <= !HOLD_AT_RESET;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      base_q      <= base_d;
      cnt_q       <= cnt_d;
      checksum_q  <= checksum_d;
      rdata_q     <= rdata_d;
      vfirst_q    <= vfirst_d;
      error_q     <= error_d;
      core_hold_q <= core_hold_d;
      busy_q      <= is_busy(state_d);
      done_q      <= (state_d == ST_DONE);
    end
  end

  // Strobes follow the stream handshake within the same cycle.
  assign bus.s_ready   = s_ready_c;
  assign bus.mem_as_L  = mem_as_c;
  assign bus.mem_we_L  = mem_we_c;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_wdata = mem_wdata_c;

  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign core_hold_L = core_hold_q;
  assign checksum    = checksum_q;

endmodule

// File: tb/tb_mem_loader.sv
// Scoreboard bench for mem_loader: expected writes are queued by the stimulus and popped by a bus monitor.
module tb_mem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [11:0] base_addr = '0;
  logic [10:0] word_count = '0;
  logic        busy, done, error, core_hold_L;
  logic [31:0] checksum;

  mem_loader_if #(.ADDR_W(12), .DATA_W(32)) bus ();

  mem_loader #(
    .ADDR_W(12), .DATA_W(32), .DEPTH(1024), .CLEAR_VAL(32'h0), .HOLD_AT_RESET(1'b1)
  ) dut (
    .CLOCK_50    (clk),
    .RESET_L     (rst_n),
    .start       (start),
    .mode        (mode),
    .base_addr   (base_addr),
    .word_count  (word_count),
    .bus         (bus),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .core_hold_L (core_hold_L),
    .checksum    (checksum)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          wr_count = 0;
  int          as_count = 0;
  int          last_wr_cyc = 0;
  logic [43:0] sb[$];
  logic [31:0] mem [1024];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: synchronous write, read data valid the cycle after the read strobe.
  always @(posedge clk) begin
    if (rst_n && !bus.mem_as_L) begin
      if (!bus.mem_we_L) mem[bus.mem_addr[11:2]] <= bus.mem_wdata;
      else               bus.mem_rdata <= mem[bus.mem_addr[11:2]];
    end
  end

  // Monitor: every write strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && !bus.mem_as_L) begin
      as_count++;
      if (!bus.mem_we_L) begin
        wr_count++;
        last_wr_cyc = cyc;
        if (sb.size() == 0) begin
          chk("unexpected_write", {20'h0, bus.mem_addr, bus.mem_wdata}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          chk("write", {20'h0, bus.mem_addr, bus.mem_wdata}, {20'h0, sb.pop_front()});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] m, input logic [11:0] b, input logic [10:0] n);
    tick();
    start = 1'b1; mode = m; base_addr = b; word_count = n;
    tick();
    start = 1'b0;
  endtask

  task automatic push_clear();
    for (int i = 0; i < 1024; i++) sb.push_back({12'(i * 4), 32'h0});
  endtask

  task automatic feed(input logic [31:0] w0, w1, w2, w3, input int n, input int gap, output int acc);
    logic [31:0] w [4];
    logic hs;
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    acc = 0;
    for (int i = 0; i < n; i++) begin
      for (int g = 1; g < gap; g++) begin bus.s_valid = 1'b0; tick(); end
      bus.s_valid = 1'b1; bus.s_data = w[i];
      hs = 1'b0;
      for (int t = 0; t < 3000 && !hs; t++) begin
        @(negedge clk); hs = bus.s_ready;
        tick();
      end
      if (!hs) begin bus.s_valid = 1'b0; return; end
      acc++;
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_end(input int max, output bit got_done, output bit got_err, output int done_cyc);
    got_done = 0; got_err = 0; done_cyc = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (done)  begin got_done = 1; done_cyc = cyc; break; end
      if (error) begin got_err = 1; break; end
    end
  endtask

  initial begin
    bit gd, ge;
    int dc, acc, w0, a0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hDEAD_BEEF;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.mem_rdata = '0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_checksum", checksum, 0);
    chk("rst_core_hold", core_hold_L, 0);
    chk("rst_strobes", {bus.mem_as_L, bus.mem_we_L, bus.s_ready}, 3'b110);
    chk("rst_addr", bus.mem_addr, 0);
    tick(); rst_n = 1'b1;

    // Clear only
    push_clear(); w0 = wr_count;
    do_start(2'b10, 12'h000, 11'd0);
    wait_end(3000, gd, ge, dc);
    chk("clr_done", gd, 1);
    chk("clr_writes", wr_count - w0, 1024);
    chk("clr_done_after_last", dc - last_wr_cyc, 1);
    chk("clr_core_hold", core_hold_L, 1);
    chk("clr_sb_empty", sb.size(), 0);
    @(negedge clk);
    chk("idle_after_done", {busy, done, core_hold_L}, 3'b001);

    // Clear + load
    push_clear();
    sb.push_back({12'h000, 32'h0000_0093}); sb.push_back({12'h004, 32'h0010_0113});
    sb.push_back({12'h008, 32'h0020_81B3}); sb.push_back({12'h00C, 32'h0000_006F});
    do_start(2'b00, 12'h000, 11'd4);
    fork
      feed(32'h0000_0093, 32'h0010_0113, 32'h0020_81B3, 32'h0000_006F, 4, 1, acc);
      wait_end(4000, gd, ge, dc);
    join
    chk("cl_done", gd, 1);
    chk("cl_checksum", checksum, 32'h0030_83C8);
    chk("cl_sb_empty", sb.size(), 0);

    // Load only, sparse valid
    sb.push_back({12'h000, 32'h0000_0093}); sb.push_back({12'h004, 32'h0010_0113});
    sb.push_back({12'h008, 32'h0020_81B3}); sb.push_back({12'h00C, 32'h0000_006F});
    w0 = wr_count;
    do_start(2'b01, 12'h000, 11'd4);
    chk("ld_checksum_cleared", checksum, 0);
    fork
      feed(32'h0000_0093, 32'h0010_0113, 32'h0020_81B3, 32'h0000_006F, 4, 3, acc);
      wait_end(200, gd, ge, dc);
    join
    chk("ld_done", gd, 1);
    chk("ld_writes", wr_count - w0, 4);
    chk("ld_checksum", checksum, 32'h0030_83C8);

    // Verify with a corrupted third word
    w0 = wr_count;
    do_start(2'b11, 12'h000, 11'd4);
    fork
      feed(32'h0000_0093, 32'h0010_0113, 32'h0020_81B4, 32'h0, 3, 1, acc);
      wait_end(200, gd, ge, dc);
    join
    chk("vf_accepted", acc, 3);
    chk("vf_error", {ge, error}, 2'b11);
    chk("vf_no_done", gd, 0);
    chk("vf_state_err", dut.state_q, 3'd6);
    repeat (4) @(negedge clk);
    chk("vf_core_hold", {core_hold_L, done, error}, 3'b001);
    chk("vf_no_writes", wr_count - w0, 0);

    // Out-of-range request
    a0 = as_count;
    do_start(2'b01, 12'hFF8, 11'd4);
    @(negedge clk);
    chk("rng_error", error, 1);
    repeat (5) @(negedge clk);
    chk("rng_no_strobe", as_count - a0, 0);
    chk("rng_busy", busy, 0);

    // Reset in the middle of a clear
    push_clear(); w0 = wr_count;
    do_start(2'b10, 12'h000, 11'd0);
    for (int i = 0; i < 3000 && (wr_count - w0) < 100; i++) @(negedge clk);
    chk("mid_reached_100", wr_count - w0, 100);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_strobes", {bus.mem_as_L, bus.mem_we_L}, 2'b11);
    chk("mid_rst_busy", busy, 0);
    sb.delete();
    tick(); rst_n = 1'b1;
    push_clear(); w0 = wr_count;
    do_start(2'b10, 12'h000, 11'd0);
    wait_end(3000, gd, ge, dc);
    chk("mid_redo_done", gd, 1);
    chk("mid_redo_writes", wr_count - w0, 1024);
    chk("mid_sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
